// File: rtl/align_frame_ctrl.sv
// Frame capture sequencer feeding the 8->32 byte aligner: sync pulse, paced data bytes,
// pad fill to a word boundary, word counting, timeout/abort error and done reporting.
module align_frame_ctrl #(
  parameter int          LEN_W    = 16,
  parameter int          TIMEOUT  = 1024,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic [7:0]       i_data,
  input  logic             i_vld,
  input  logic             i_word_vld,
  output logic             o_sync,
  output logic [7:0]       o_data,
  output logic             o_wren,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [LEN_W-1:0] o_word_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_PAD,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [1:0]       pad_cnt_reg, pad_cnt_next;
  logic [TO_W-1:0]  idle_cnt_reg, idle_cnt_next;

  logic             sync_next;
  logic [7:0]       data_next;
  logic             wren_next;
  logic             busy_next;
  logic             done_next;
  logic             err_next;
  logic [LEN_W-1:0] word_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      pad_cnt_reg  <= '0;
      idle_cnt_reg <= '0;
      o_sync       <= 1'b0;
      o_data       <= 8'h00;
      o_wren       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_word_cnt   <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      pad_cnt_reg  <= pad_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
      o_sync       <= sync_next;
      o_data       <= data_next;
      o_wren       <= wren_next;
      o_busy       <= busy_next;
      o_done       <= done_next;
      o_err        <= err_next;
      o_word_cnt   <= word_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    pad_cnt_next  = pad_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    sync_next     = 1'b0;
    data_next     = o_data;
    wren_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = o_err;
    word_cnt_next = o_word_cnt;

    // Words from the aligner are counted through the DONE cycle so the count is final at o_done.
    if (state_reg != ST_IDLE && i_word_vld)
      word_cnt_next = o_word_cnt + LEN_W'(1);

    unique case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          len_next      = i_frame_len;
          err_next      = 1'b0;
          word_cnt_next = '0;
          byte_cnt_next = '0;
          idle_cnt_next = '0;
          state_next    = (i_frame_len == '0) ? ST_DONE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        sync_next  = 1'b1;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (i_vld) begin
          data_next     = i_data;
          wren_next     = 1'b1;
          byte_cnt_next = byte_cnt_reg + LEN_W'(1);
          idle_cnt_next = '0;
          if (byte_cnt_reg == len_reg - LEN_W'(1)) begin
            if (len_reg[1:0] == 2'd0) begin
              state_next = ST_DONE;
            end else begin
              // 4 - len[1:0] in two bits: 1->3, 2->2, 3->1
              pad_cnt_next = 2'd0 - len_reg[1:0];
              state_next   = ST_PAD;
            end
          end
        end else if (idle_cnt_reg + TO_W'(1) == TO_W'(TIMEOUT)) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          idle_cnt_next = idle_cnt_reg + TO_W'(1);
        end
      end
      ST_PAD: begin
        data_next    = PAD_BYTE;
        wren_next    = 1'b1;
        pad_cnt_next = pad_cnt_reg - 2'd1;
        if (pad_cnt_reg == 2'd1)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort overrides every other event once a frame is in flight.
    if (i_abort && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
      err_next   = 1'b1;
      sync_next  = 1'b0;
      wren_next  = 1'b0;
      done_next  = 1'b0;
    end

    busy_next = (state_next != ST_IDLE);
  end

endmodule
